ping_pong_counter_gen: RTL and testbench
========================================

Name: ping_pong_counter_gen

Overview:
- Parametrised successor to the 4-bit ping-pong counter.
- Configurable data width and step size.
- Four run modes: ping-pong, wrap-up, wrap-down and hold.
- Synchronous load, a bound-event pulse and an invalid-configuration flag.
- Used as the general sweep/scan counter for display and LED sequencing blocks.

Parameters:
- WIDTH, 8, counter/bound width in bits.
- STEP_W, 4, width of the step-size input.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  advance counter this cycle.
- flip  in  1  ping-pong mode only: reverse direction this cycle (requires enable).
- mode  in  2  0=PINGPONG, 1=WRAP_UP, 2=WRAP_DOWN, 3=HOLD.
- max  in  WIDTH  upper bound, inclusive.
- min  in  WIDTH  lower bound, inclusive.
- step  in  STEP_W  increment magnitude; 0 treated as 1.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- out  out  WIDTH  registered count.
- direction  out  1  registered, 1=up, 0=down.
- bound  out  1  registered 1-cycle pulse on bound reversal or wrap.
- invalid  out  1  combinational: (min>=max) || out<min || out>max.

Behaviour:
- Reset (rst_n=0 at posedge): out<=min, direction<=1, bound<=0. Reset overrides load/enable and takes effect mid-sweep.
- Priority: reset > load > enable. enable=0 and load=0: all registers hold, bound<=0.
- Load: if min<=load_val<=max and min<max, out<=load_val, direction unchanged. Otherwise the load is ignored and out holds. bound<=0 on any load cycle.
- Invalid hold: enable=1 with invalid=1 -> out, direction hold; bound<=0. No self-recovery; requires load or reset.
- Effective step: s=(step==0)?1:step. Arithmetic uses WIDTH+1 bits, so no overflow or underflow wrap ever reaches out.
- Latency: one cycle from enable to the updated out.
- PINGPONG, enable=1, valid:
  - Direction d first becomes d'=flip?~d:d.
  - d'=1, out==max: out<=max(out-s,min), direction<=0, bound<=1.
  - d'=1, otherwise: out<=min(out+s,max), direction<=1.
  - d'=0, out==min: out<=min(out+s,max), direction<=1, bound<=1.
  - d'=0, otherwise: out<=max(out-s,min), direction<=0.
  - Flip at a bound toward the outside: reversal rule applies, so out moves inward and bound pulses.
- WRAP_UP, enable=1, valid: direction<=1; out==max -> out<=min, bound<=1; else out<=min(out+s,max). flip ignored.
- WRAP_DOWN, enable=1, valid: direction<=0; out==min -> out<=max, bound<=1; else out<=max(out-s,min). flip ignored.
- HOLD: out, direction hold; bound<=0; load still honoured.
- Mode or bound changes take effect on the next enabled cycle, with no pipeline.
- If bounds change so out falls outside [min,max], invalid asserts and the counter holds until load or reset.

Test Plan:
- WIDTH=8, rst_n=0 then enable=1, PINGPONG, min=3, max=6, step=1 -> out 3,4,5,6,5,4,3,4; direction 1,1,1,1→0 after 6, →1 after 3; bound pulses the cycle out leaves 6 and leaves 3.
- PINGPONG, min=0, max=10, step=3 -> out 0,3,6,9,10,7,4,1,0,3. bound pulses on 10→7 and 0→3. step=0 with min=0, max=2 -> 0,1,2,1,0.
- PINGPONG, min=0, max=15, out=5 dir up, flip=1 one cycle -> out=4, dir=0. Flip at out=15 dir=0 -> out=14, dir=0, bound=1.
- WRAP_UP, min=2, max=5, step=2 -> 2,4,5,2,4; bound on 5→2. WRAP_DOWN same bounds -> 5,3,2,5; direction constant.
- Invalid config: min=7, max=7, enable=1 -> out holds at 7, invalid=1. Then load=1, load_val=20 with min=0, max=15 -> ignored. load_val=9 -> out=9.
- Reset mid-sweep at out=9 dir=0 (min=4) -> next cycle out=4, dir=1, bound=0. Simultaneous load=1 and enable=1 -> load wins, no step.

Source files
------------

// File: rtl/ping_pong_counter_gen.sv
// Parametrised sweep/scan counter with four run modes: ping-pong between
// [min,max], wrap-up, wrap-down and hold. Adds a synchronous load, a
// one-cycle bound pulse on reversal or wrap, and a combinational
// invalid-configuration flag.
module ping_pong_counter_gen #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flip,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  max,
  input  logic [WIDTH-1:0]  min,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              direction,
  output logic              bound,
  output logic              invalid
);

  typedef enum logic [1:0] {
    PINGPONG  = 2'd0,
    WRAP_UP   = 2'd1,
    WRAP_DOWN = 2'd2,
    HOLD      = 2'd3
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic             dn_under;
  logic [WIDTH-1:0] up_sat;
  logic [WIDTH-1:0] dn_sat;
  logic             load_ok;
  logic             d_eff;
  logic [WIDTH-1:0] out_n;
  logic             dir_n;
  logic             bound_n;

  assign mode_sel = mode_e'(mode);
  assign invalid  = (min >= max) || (out < min) || (out > max);
  assign load_ok  = (min < max) && (load_val >= min) && (load_val <= max);
  assign d_eff    = flip ? ~direction : direction;

  // Saturating step arithmetic in WIDTH+1 bits so the sum/difference can
  // never wrap before being clamped to the bounds.
  always_comb begin
    s_ext    = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
    up_sum   = {1'b0, out} + s_ext;
    dn_diff  = {1'b0, out} - s_ext;
    dn_under = ({1'b0, out} < s_ext);
    up_sat   = (up_sum > {1'b0, max}) ? max : up_sum[WIDTH-1:0];
    dn_sat   = (dn_under || (dn_diff < {1'b0, min})) ? min : dn_diff[WIDTH-1:0];
  end

  // Next-state selection: load beats enable; invalid configuration freezes.
  always_comb begin
    out_n   = out;
    dir_n   = direction;
    bound_n = 1'b0;
    if (load) begin
      if (load_ok) out_n = load_val;
    end else if (enable && !invalid) begin
      case (mode_sel)
        PINGPONG: begin
          // Reversal is decided on the post-flip direction, so a flip that
          // points outward at a bound still bounces the count inward.
          if (d_eff) begin
            if (out == max) begin
              out_n   = dn_sat;
              dir_n   = 1'b0;
              bound_n = 1'b1;
            end else begin
              out_n = up_sat;
              dir_n = 1'b1;
            end
          end else begin
            if (out == min) begin
              out_n   = up_sat;
              dir_n   = 1'b1;
              bound_n = 1'b1;
            end else begin
              out_n = dn_sat;
              dir_n = 1'b0;
            end
          end
        end
        WRAP_UP: begin
          dir_n = 1'b1;
          if (out == max) begin
            out_n   = min;
            bound_n = 1'b1;
          end else begin
            out_n = up_sat;
          end
        end
        WRAP_DOWN: begin
          dir_n = 1'b0;
          if (out == min) begin
            out_n   = max;
            bound_n = 1'b1;
          end else begin
            out_n = dn_sat;
          end
        end
        default: begin
          out_n = out;
          dir_n = direction;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset to the lower bound.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= min;
      direction <= 1'b1;
      bound     <= 1'b0;
    end else begin
      out       <= out_n;
      direction <= dir_n;
      bound     <= bound_n;
    end
  end

endmodule

// File: tb/tb_ping_pong_counter_gen.sv
// Table-driven bench for ping_pong_counter_gen. Each row drives one cycle of
// stimulus and pushes the expected {out,direction,bound,invalid} onto a
// scoreboard queue, which is popped and compared after the clock edge.
module tb_ping_pong_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       flip;
  logic [1:0] mode;
  logic [7:0] max;
  logic [7:0] min;
  logic [3:0] step;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] out;
  logic       direction;
  logic       bound;
  logic       invalid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       r;
    logic       l;
    logic       en;
    logic       f;
    logic [1:0] m;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [3:0] stp;
    logic [7:0] lv;
    logic [7:0] o;
    logic       d;
    logic       b;
    logic       inv;
  } row_t;

  logic [10:0] sb[$];

  ping_pong_counter_gen #(.WIDTH(8), .STEP_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .flip     (flip),
    .mode     (mode),
    .max      (max),
    .min      (min),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .direction(direction),
    .bound    (bound),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic row_t mk(input bit r, input bit l, input bit en, input bit f,
                              input int m, input int mn, input int mx, input int stp,
                              input int lv, input int o, input bit d, input bit b,
                              input bit inv);
    row_t x;
    x.r = r; x.l = l; x.en = en; x.f = f; x.m = 2'(m);
    x.mn = 8'(mn); x.mx = 8'(mx); x.stp = 4'(stp); x.lv = 8'(lv);
    x.o = 8'(o); x.d = d; x.b = b; x.inv = inv;
    return x;
  endfunction

  task automatic drive(input row_t x);
    rst_n    = x.r;
    load     = x.l;
    enable   = x.en;
    flip     = x.f;
    mode     = x.m;
    min      = x.mn;
    max      = x.mx;
    step     = x.stp;
    load_val = x.lv;
    sb.push_back({x.o, x.d, x.b, x.inv});
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(mk(0,0,1,0, 0,3,6,1,0,   3,1,0,0));
    rows.push_back(mk(0,1,1,0, 0,3,6,1,5,   3,1,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL reset row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_pingpong();
    row_t rows[$];
    logic [10:0] e;
    // min=3 max=6 step=1
    rows.push_back(mk(0,0,1,0, 0,3,6,1,0,   3,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   4,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   5,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   6,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   5,0,1,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   4,0,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   3,0,0,0));
    rows.push_back(mk(1,0,1,0, 0,3,6,1,0,   4,1,1,0));
    rows.push_back(mk(1,0,0,0, 0,3,6,1,0,   4,1,0,0));
    // min=0 max=10 step=3, saturating at both ends
    rows.push_back(mk(0,0,1,0, 0,0,10,3,0,  0,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  3,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  6,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  9,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0, 10,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  7,0,1,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  4,0,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  1,0,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  0,0,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,10,3,0,  3,1,1,0));
    // step=0 behaves as step=1
    rows.push_back(mk(0,0,1,0, 0,0,2,0,0,   0,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,2,0,0,   1,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,2,0,0,   2,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,2,0,0,   1,0,1,0));
    rows.push_back(mk(1,0,1,0, 0,0,2,0,0,   0,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL pingpong row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_flip();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(mk(0,0,0,0, 0,0,15,1,0,  0,1,0,0));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,5,  5,1,0,0));
    rows.push_back(mk(1,0,1,1, 0,0,15,1,0,  4,0,0,0));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,15, 15,0,0,0));
    rows.push_back(mk(1,0,1,1, 0,0,15,1,0, 14,0,1,0));
    rows.push_back(mk(1,0,0,0, 0,0,15,1,0, 14,0,0,0));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,0,  0,0,0,0));
    rows.push_back(mk(1,0,1,1, 0,0,15,1,0,  1,1,0,0));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,0,  0,1,0,0));
    rows.push_back(mk(1,0,1,1, 0,0,15,1,0,  1,1,1,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL flip row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(mk(0,0,1,0, 1,2,5,2,0,   2,1,0,0));
    rows.push_back(mk(1,0,1,0, 1,2,5,2,0,   4,1,0,0));
    rows.push_back(mk(1,0,1,0, 1,2,5,2,0,   5,1,0,0));
    rows.push_back(mk(1,0,1,0, 1,2,5,2,0,   2,1,1,0));
    rows.push_back(mk(1,0,1,0, 1,2,5,2,0,   4,1,0,0));
    rows.push_back(mk(1,0,1,1, 1,2,5,2,0,   5,1,0,0));
    rows.push_back(mk(1,1,0,0, 2,2,5,2,5,   5,1,0,0));
    rows.push_back(mk(1,0,1,0, 2,2,5,2,0,   3,0,0,0));
    rows.push_back(mk(1,0,1,0, 2,2,5,2,0,   2,0,0,0));
    rows.push_back(mk(1,0,1,0, 2,2,5,2,0,   5,0,1,0));
    rows.push_back(mk(1,1,1,0, 2,2,5,2,4,   4,0,0,0));
    rows.push_back(mk(1,0,1,1, 2,2,5,2,0,   2,0,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL wrap row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_invalid();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(mk(0,0,1,0, 0,7,7,1,0,   7,1,0,1));
    rows.push_back(mk(1,0,1,0, 0,7,7,1,0,   7,1,0,1));
    rows.push_back(mk(1,0,1,0, 1,7,7,1,0,   7,1,0,1));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,20, 7,1,0,0));
    rows.push_back(mk(1,1,0,0, 0,0,15,1,9,  9,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,0,8,1,0,   9,1,0,1));
    rows.push_back(mk(1,0,1,0, 0,0,8,1,0,   9,1,0,1));
    rows.push_back(mk(1,1,0,0, 0,0,8,1,5,   5,1,0,0));
    rows.push_back(mk(1,1,0,0, 0,7,7,1,7,   5,1,0,1));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL invalid row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(mk(0,0,0,0, 0,4,15,1,0,  4,1,0,0));
    rows.push_back(mk(1,1,0,0, 0,4,15,1,10, 10,1,0,0));
    rows.push_back(mk(1,0,1,0, 2,4,15,1,0,  9,0,0,0));
    rows.push_back(mk(0,1,1,0, 0,4,15,1,12, 4,1,0,0));
    rows.push_back(mk(1,1,1,0, 0,4,15,1,12, 12,1,0,0));
    rows.push_back(mk(1,0,1,1, 3,4,15,1,0, 12,1,0,0));
    rows.push_back(mk(1,0,0,0, 0,4,15,1,0, 12,1,0,0));
    rows.push_back(mk(1,0,1,0, 0,4,15,1,0, 13,1,0,0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if ({out, direction, bound, invalid} !== e) begin
        n_fail++;
        $display("FAIL back_to_back row %0d: got out=%0d dir=%b bound=%b inv=%b, expected out=%0d dir=%b bound=%b inv=%b",
                 i, out, direction, bound, invalid, e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    flip     = 1'b0;
    mode     = 2'd0;
    min      = 8'd0;
    max      = 8'd15;
    step     = 4'd1;
    load     = 1'b0;
    load_val = 8'd0;
    test_reset();
    test_pingpong();
    test_flip();
    test_wrap();
    test_invalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
